// File: rtl/trolley_system_stream_loader.sv
// Packs a sop/eop byte stream little-endian into 32-bit words, writes them to consecutive memory words, optionally reads back and checks.
// Latency: 7 cycles per full word with VERIFY=1 (4 fill + write + read + check), 5 cycles with VERIFY=0; done one cycle after the last word.
// Backpressure: in_ready is high only while filling a word; it is low during the write/read/check cycles and while idle.
module trolley_system_stream_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int BASE_WORD  = 0,
    parameter int VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    input  logic [31:0]           mem_readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  wrapped,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_CHECK = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_WORD);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            idx_q, idx_d;
    logic                  in_packet_q, in_packet_d;
    logic                  eop_q, eop_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  error_q, error_d;
    logic                  wrapped_q, wrapped_d;
    logic                  done_q, done_d;
    logic                  clken_q;
    logic [31:0]           lane_mask;

    assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        in_packet_d = in_packet_q;
        eop_d       = eop_q;
        count_d     = count_q;
        error_d     = error_q;
        wrapped_d   = wrapped_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = BASE_ADDR;
                    count_d     = '0;
                    error_d     = 1'b0;
                    wrapped_d   = 1'b0;
                    idx_d       = 2'd0;
                    be_d        = 4'd0;
                    wdata_d     = 32'd0;
                    in_packet_d = 1'b0;
                    eop_d       = 1'b0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                // Bytes before the first sop are swallowed so a loader armed mid-stream resyncs.
                if (in_valid && (in_packet_q || in_sop)) begin
                    in_packet_d                     = 1'b1;
                    wdata_d[{idx_q, 3'b000} +: 8]   = in_data;
                    be_d[idx_q]                     = 1'b1;
                    idx_d                           = idx_q + 2'd1;
                    if (idx_q == 2'd3 || in_eop) begin
                        eop_d   = in_eop;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                count_d = count_q + CNT_ONE;
                if (VERIFY != 0) begin
                    state_d = S_READ;
                end else begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d    = '0;
                        wrapped_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                    idx_d   = 2'd0;
                    be_d    = 4'd0;
                    wdata_d = 32'd0;
                    state_d = eop_q ? S_IDLE : S_FILL;
                    done_d  = eop_q;
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (((mem_readdata ^ wdata_q) & lane_mask) != 32'd0) begin
                    error_d = 1'b1;
                end
                if (addr_q == LAST_ADDR) begin
                    addr_d    = '0;
                    wrapped_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
                idx_d   = 2'd0;
                be_d    = 4'd0;
                wdata_d = 32'd0;
                state_d = eop_q ? S_IDLE : S_FILL;
                done_d  = eop_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            idx_q       <= 2'd0;
            in_packet_q <= 1'b0;
            eop_q       <= 1'b0;
            count_q     <= '0;
            error_q     <= 1'b0;
            wrapped_q   <= 1'b0;
            done_q      <= 1'b0;
            clken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            in_packet_q <= in_packet_d;
            eop_q       <= eop_d;
            count_q     <= count_d;
            error_q     <= error_d;
            wrapped_q   <= wrapped_d;
            done_q      <= done_d;
            clken_q     <= 1'b1;
        end
    end

    assign in_ready       = (state_q == S_FILL);
    assign busy           = (state_q != S_IDLE);
    assign mem_chipselect = (state_q == S_WRITE) || (state_q == S_READ);
    assign mem_write      = (state_q == S_WRITE);
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = clken_q;
    assign done           = done_q;
    assign error          = error_q;
    assign wrapped        = wrapped_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_trolley_system_stream_loader.sv
// Bench for the stream loader: a verifying instance at base 0 and a write-only instance at base 4095,
// each driving its own byte-enabled memory with a registered read address.
module tb_trolley_system_stream_loader;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    int          sel = 0;
    logic        corrupt = 1'b0;
    int          cyc = 0;
    int          checks = 0, errors = 0;
    int          done_cnt0 = 0;

    logic        iv0, iv1;
    logic        ir0, cs0, we0, ck0, busy0, done0, err0, wrap0;
    logic        ir1, cs1, we1, ck1, busy1, done1, err1, wrap1;
    logic [11:0] addr0, addr1, raddr0;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1, rd0, rd1;
    logic [12:0] wc0, wc1;
    logic [31:0] mem0 [0:4095];
    logic [31:0] mem1 [0:4095];

    wr_t         exp0[$], exp1[$];
    logic [7:0]  bq[$];
    bit          sq[$], eq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);

    trolley_system_stream_loader #(.ADDR_WIDTH(12), .DEPTH(4096), .BASE_WORD(0), .VERIFY(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .in_data(in_data), .in_valid(iv0), .in_ready(ir0), .in_sop(in_sop), .in_eop(in_eop),
        .mem_address(addr0), .mem_byteenable(be0), .mem_chipselect(cs0), .mem_write(we0),
        .mem_writedata(wd0), .mem_clken(ck0), .mem_readdata(rd0),
        .busy(busy0), .done(done0), .error(err0), .wrapped(wrap0), .word_count(wc0)
    );

    trolley_system_stream_loader #(.ADDR_WIDTH(12), .DEPTH(4096), .BASE_WORD(4095), .VERIFY(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .in_data(in_data), .in_valid(iv1), .in_ready(ir1), .in_sop(in_sop), .in_eop(in_eop),
        .mem_address(addr1), .mem_byteenable(be1), .mem_chipselect(cs1), .mem_write(we1),
        .mem_writedata(wd1), .mem_clken(ck1), .mem_readdata(rd1),
        .busy(busy1), .done(done1), .error(err1), .wrapped(wrap1), .word_count(wc1)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (cs0) begin
            if (we0) mem0[addr0] <= merge(mem0[addr0], wd0, be0);
            else     raddr0 <= addr0;
        end
        if (cs1 && we1) mem1[addr1] <= merge(mem1[addr1], wd1, be1);
    end

    assign rd0 = mem0[raddr0] ^ {31'd0, corrupt};
    assign rd1 = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Per-cycle compare: every memory write must be the next word the model expects.
    always @(negedge clk) begin
        wr_t w;
        if (reset_n) begin
            if (cs0 && we0) begin
                if (exp0.size() == 0) chk("dut0_unexpected_write", 32'd1, 32'd0);
                else begin
                    w = exp0.pop_front();
                    chk("dut0_wr_addr", {20'd0, addr0}, {20'd0, w.a});
                    chk("dut0_wr_data", wd0, w.d);
                    chk("dut0_wr_be", {28'd0, be0}, {28'd0, w.be});
                end
            end
            if (cs1 && we1) begin
                if (exp1.size() == 0) chk("dut1_unexpected_write", 32'd1, 32'd0);
                else begin
                    w = exp1.pop_front();
                    chk("dut1_wr_addr", {20'd0, addr1}, {20'd0, w.a});
                    chk("dut1_wr_data", wd1, w.d);
                    chk("dut1_wr_be", {28'd0, be1}, {28'd0, w.be});
                end
            end
            if (cs0) chk("dut0_ready_during_mem", {31'd0, ir0}, 32'd0);
            if (cs1) chk("dut1_ready_during_mem", {31'd0, ir1}, 32'd0);
        end
        if (done0) done_cnt0++;
    end

    task automatic add_byte(input logic [7:0] b, input bit s, input bit e);
        bq.push_back(b); sq.push_back(s); eq.push_back(e);
    endtask

    // Packs the queued stream the way a packet should land in memory.
    task automatic model(input int dut, input int base, output int nw, output bit wr);
        bit in_pkt; int idx; int a; logic [31:0] d; logic [3:0] be; wr_t w;
        in_pkt = 0; idx = 0; a = base; d = 0; be = 0; nw = 0; wr = 0;
        for (int i = 0; i < bq.size(); i++) begin
            if (!in_pkt && !sq[i]) continue;
            in_pkt = 1;
            d[8*idx +: 8] = bq[i];
            be[idx] = 1'b1;
            idx++;
            if (idx == 4 || eq[i]) begin
                w.a = 12'(a); w.d = d; w.be = be;
                if (dut == 0) exp0.push_back(w); else exp1.push_back(w);
                nw++;
                if (a == 4095) begin a = 0; wr = 1; end else a++;
                idx = 0; d = 0; be = 0;
                if (eq[i]) break;
            end
        end
    endtask

    task automatic pulse_start(input int dut);
        @(posedge clk); #1;
        if (dut == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic send_all(output int c_first);
        int n;
        c_first = 0;
        for (int i = 0; i < bq.size(); i++) begin
            in_valid = 1'b1; in_data = bq[i]; in_sop = sq[i]; in_eop = eq[i];
            n = 0;
            forever begin
                @(negedge clk);
                if ((sel == 0) ? ir0 : ir1) break;
                n++;
                if (n > 50) break;
            end
            if (n > 50) begin
                chk("send_ready_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
            if (i == 0) c_first = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic wait_done(input int dut, output int c_done);
        c_done = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((dut == 0) ? done0 : done1) begin
                c_done = cyc;
                return;
            end
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_stream();
        bq.delete(); sq.delete(); eq.delete();
    endtask

    initial begin
        int c0, cd, nw, dcnt;
        bit wr;

        // Reset state
        #12;
        chk("rst_clken", {31'd0, ck0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_ready", {31'd0, ir0}, 32'd0);
        chk("rst_cs", {31'd0, cs0}, 32'd0);
        chk("rst_wc", {19'd0, wc0}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("clken_after_rst", {31'd0, ck0}, 32'd1);
        chk("idle_ready", {31'd0, ir0}, 32'd0);

        // 8-byte packet 0x11..0x88, verify on
        sel = 0; clear_stream();
        for (int k = 1; k <= 8; k++) add_byte(8'(k * 17), k == 1, k == 8);
        model(0, 0, nw, wr);
        pulse_start(0);
        chk("busy_after_start", {31'd0, busy0}, 32'd1);
        send_all(c0);
        wait_done(0, cd);
        chk("t1_latency", cd - c0, 14);
        chk("t1_busy_at_done", {31'd0, busy0}, 32'd0);
        chk("t1_wc", {19'd0, wc0}, nw);
        chk("t1_wc_lit", {19'd0, wc0}, 32'd2);
        chk("t1_err", {31'd0, err0}, 32'd0);
        @(negedge clk);
        chk("t1_done_one_cycle", {31'd0, done0}, 32'd0);
        chk("t1_mem0", mem0[0], 32'h44332211);
        chk("t1_mem1", mem0[1], 32'h88776655);

        // 5-byte packet: partial second word keeps prior upper lanes
        clear_stream();
        for (int k = 0; k < 5; k++) add_byte(8'(8'hA0 + k), k == 0, k == 4);
        model(0, 0, nw, wr);
        pulse_start(0);
        send_all(c0);
        wait_done(0, cd);
        chk("t2_wc", {19'd0, wc0}, 32'd2);
        chk("t2_mem0", mem0[0], 32'hA3A2A1A0);
        chk("t2_mem1", mem0[1], 32'h887766A4);

        // 3 bytes without sop are dropped before the packet
        clear_stream();
        add_byte(8'hE1, 0, 0); add_byte(8'hE2, 0, 0); add_byte(8'hE3, 0, 0);
        for (int k = 1; k <= 4; k++) add_byte(8'(k), k == 1, k == 4);
        model(0, 0, nw, wr);
        pulse_start(0);
        send_all(c0);
        wait_done(0, cd);
        chk("t3_wc", {19'd0, wc0}, 32'd1);
        chk("t3_mem0", mem0[0], 32'h04030201);

        // Reset during the read of word 1
        clear_stream();
        for (int k = 0; k < 8; k++) add_byte(8'(8'hB0 + k), k == 0, k == 7);
        model(0, 0, nw, wr);
        pulse_start(0);
        send_all(c0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cs0 && !we0) break;
        end
        chk("t4_in_read_word1", {19'd0, wc0}, 32'd2);
        dcnt = done_cnt0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_busy", {31'd0, busy0}, 32'd0);
        chk("t4_rst_cs", {31'd0, cs0}, 32'd0);
        chk("t4_rst_addr", {20'd0, addr0}, 32'd0);
        chk("t4_rst_wd", wd0, 32'd0);
        chk("t4_rst_be", {28'd0, be0}, 32'd0);
        chk("t4_rst_wc", {19'd0, wc0}, 32'd0);
        chk("t4_rst_clken", {31'd0, ck0}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_no_done", done_cnt0, dcnt);
        chk("t4_word0_kept", mem0[0], 32'hB3B2B1B0);
        clear_stream();
        for (int k = 0; k < 4; k++) add_byte(8'(8'hC0 + k), k == 0, k == 3);
        model(0, 0, nw, wr);
        pulse_start(0);
        send_all(c0);
        wait_done(0, cd);
        chk("t4_fresh_wc", {19'd0, wc0}, 32'd1);
        chk("t4_fresh_mem0", mem0[0], 32'hC3C2C1C0);

        // Wrap instance: base 4095, write only
        sel = 1; clear_stream();
        for (int k = 1; k <= 8; k++) add_byte(8'(k * 17), k == 1, k == 8);
        model(1, 4095, nw, wr);
        pulse_start(1);
        send_all(c0);
        wait_done(1, cd);
        chk("t5_latency", cd - c0, 10);
        chk("t5_wrapped", {31'd0, wrap1}, {31'd0, wr});
        chk("t5_wrapped_lit", {31'd0, wrap1}, 32'd1);
        chk("t5_wc", {19'd0, wc1}, 32'd2);
        @(negedge clk);
        chk("t5_mem4095", mem1[4095], 32'h44332211);
        chk("t5_mem0", mem1[0], 32'h88776655);

        // Read-back corruption sets a sticky error, cleared by the next start
        sel = 0; clear_stream();
        for (int k = 0; k < 4; k++) add_byte(8'(8'hD0 + k), k == 0, k == 3);
        model(0, 0, nw, wr);
        corrupt = 1'b1;
        pulse_start(0);
        send_all(c0);
        wait_done(0, cd);
        chk("t6_err_at_done", {31'd0, err0}, 32'd1);
        corrupt = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", {31'd0, err0}, 32'd1);
        pulse_start(0);
        chk("t6_err_cleared", {31'd0, err0}, 32'd0);

        chk("exp0_drained", exp0.size(), 32'd0);
        chk("exp1_drained", exp1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trolley_system_stream_loader.md
# trolley_system_stream_loader

Avalon-ST to Avalon-MM loader that sits directly upstream of the 4096 x 32 on-chip memory's s1 slave. It packs an 8-bit byte stream (boot image or route table from the UART/host link) little-endian into 32-bit words and writes them to consecutive word addresses. When enabled, it reads back every word and compares it against what was written. It reports completion, word count, verify errors and address wrap to the control CSR block.

## Interface

Parameters:
- ADDR_WIDTH, 12, word address width of the target memory
- DEPTH, 4096, number of 32-bit words in the target memory
- BASE_WORD, 0, first word address written after start
- VERIFY, 1, 1 = read back and compare each word, 0 = write only

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; arms the loader (ignored while busy)
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  loader accepts byte this cycle
- in_sop  in  1  first byte of packet
- in_eop  in  1  last byte of packet
- mem_address  out  ADDR_WIDTH  word address to memory s1
- mem_byteenable  out  4  lane enables, bit0 = bits 7:0
- mem_chipselect  out  1  memory select
- mem_write  out  1  write strobe
- mem_writedata  out  32  packed word
- mem_clken  out  1  memory clock enable
- mem_readdata  in  32  memory read data
- busy  out  1  loader armed or transferring
- done  out  1  one-cycle pulse when the last word has been written and checked
- error  out  1  sticky verify mismatch, cleared by start
- wrapped  out  1  sticky, set when the address wraps DEPTH-1 -> 0, cleared by start
- word_count  out  ADDR_WIDTH+1  words written since start

## Operation

- States: IDLE, FILL, WRITE, READ, CHECK.
- Reset values: state IDLE.
  - in_ready, busy, done, error, wrapped, mem_chipselect, mem_write: 0.
  - mem_address: 0. mem_byteenable: 0. mem_writedata: 0. word_count: 0.
  - mem_clken: 0 in reset, 1 otherwise.
- IDLE:
  - in_ready = 0.
  - On start: load address = BASE_WORD, clear word_count, error, wrapped and the byte index, set in_packet = 0, go to FILL.
- FILL:
  - in_ready = 1. A byte is accepted when in_valid & in_ready.
  - While in_packet = 0, bytes without in_sop are accepted and discarded.
  - A byte with in_sop sets in_packet = 1 and is stored.
  - An in_sop seen while in_packet = 1 is treated as ordinary data.
  - Byte k of a word (k = 0..3) goes to bits 8k+7:8k and sets byteenable bit k.
  - After the 4th byte, or on any byte with in_eop, go to WRITE. The eop flag is latched.
  - A byte carrying both sop and eop produces a one-byte word with byteenable 0001.
- WRITE:
  - One cycle with mem_chipselect = 1 and mem_write = 1; address, byteenable and writedata are held stable.
  - word_count increments.
  - Go to READ if VERIFY = 1.
  - If VERIFY = 0: advance the address, then go to FILL, or to IDLE with a done pulse if eop was latched.
- READ:
  - One cycle with mem_chipselect = 1, mem_write = 0, same address; go to CHECK.
- CHECK:
  - Compare mem_readdata with the latched word on enabled lanes only. A mismatch sets error.
  - Advance the address, clear the byte index and byteenable, then go to FILL, or to IDLE with a done pulse if eop was latched.
- Address advance: address + 1. At DEPTH-1 it wraps to 0 and sets wrapped. Writing continues; overwrite is the host's problem.
- busy = 1 in every state except IDLE.
- start outside IDLE is ignored.
- Reset mid-operation: everything returns to reset values. A partially packed word is discarded. Memory contents already written are untouched.

## Timing

- Memory write takes effect at the rising edge that ends the WRITE cycle.
- Memory read: address registered at the edge ending READ; data is valid combinationally during CHECK and sampled at the edge ending CHECK.
- Per full word with back-to-back bytes:
  - VERIFY = 1: 4 FILL + WRITE + READ + CHECK = 7 cycles.
  - VERIFY = 0: 5 cycles.
- in_ready is low for the 3 (or 1) cycles following the accepting edge of the 4th or eop byte.
- done is asserted for one cycle in the first IDLE cycle. busy falls in that same cycle.
- word_count is updated at the edge ending WRITE.

## Test plan

- 8-byte packet 0x11..0x88, sop on first, eop on last, BASE_WORD 0, VERIFY 1 -> 0x44332211 @0, 0x88776655 @1, both byteenable 1111; word_count 2, done pulse, error 0, 14 cycles from first byte to done.
- 5-byte packet 0xA0..0xA4 -> word 0 = 0xA3A2A1A0 with BE 1111; word 1 writes 0x000000A4 with BE 0001; lanes 3:1 of word 1 keep their prior value.
- 3 bytes without sop, then a 4-byte packet 0x01..0x04 -> first 3 discarded; 0x04030201 @BASE_WORD; word_count 1.
- Bench forces mem_readdata bit 0 flipped during CHECK -> error = 1 stays set through done; cleared on next start.
- BASE_WORD 4095, 8-byte packet -> writes @4095 then @0, wrapped = 1, word_count 2.
- reset_n low during the READ of word 1 -> all outputs at reset values next cycle, done never pulses; word 0 remains in memory; a fresh start then loads normally.
